// File: rtl/instr_decode_queue.sv
// Decode-and-buffer stage between fetch and issue: decodes each instruction on
// enqueue and holds decoded records in a DEPTH-entry FIFO presented in order.
module instr_decode_queue #(
  parameter int XLEN           = 32,
  parameter int DEPTH          = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_instr,
  input  logic [XLEN-1:0]               in_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
  output logic [6:0]                    out_opcode,
  output logic [REG_ADDR_WIDTH-1:0]     out_rd,
  output logic [REG_ADDR_WIDTH-1:0]     out_rs1,
  output logic [REG_ADDR_WIDTH-1:0]     out_rs2,
  output logic [2:0]                    out_funct3,
  output logic [6:0]                    out_funct7,
  output logic [2:0]                    out_fmt,
  output logic [XLEN-1:0]               out_imm,
  output logic                          out_rd_used,
  output logic                          out_rs1_used,
  output logic                          out_rs2_used,
  output logic                          out_illegal,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_OP_IMM32 = 7'h1B;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_OP32     = 7'h3B;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]           pc;
    logic [6:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [2:0]                fmt;
    logic [XLEN-1:0]           imm;
    logic                      rd_used;
    logic                      rs1_used;
    logic                      rs2_used;
    logic                      illegal;
  } entry_t;

  function automatic logic [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic [2:0]         fmt_p0;
  logic signed [31:0] imm32_p0;
  logic               is_system_p0;
  logic               sys_rs1_p0;
  logic               rd_nz_p0;
  entry_t             dec_p0;

  // Stage p0: combinational decode of the incoming word
  always_comb begin
    fmt_p0 = FMT_NONE;
    case (in_instr[6:0])
      OPC_OP:       fmt_p0 = FMT_R;
      OPC_OP32:     fmt_p0 = (XLEN == 64) ? FMT_R : FMT_NONE;
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM:
                    fmt_p0 = FMT_I;
      OPC_OP_IMM32: fmt_p0 = (XLEN == 64) ? FMT_I : FMT_NONE;
      OPC_STORE:    fmt_p0 = FMT_S;
      OPC_BRANCH:   fmt_p0 = FMT_B;
      OPC_LUI, OPC_AUIPC: fmt_p0 = FMT_U;
      OPC_JAL:      fmt_p0 = FMT_J;
      default:      fmt_p0 = FMT_NONE;
    endcase
    if (in_instr[1:0] != 2'b11) fmt_p0 = FMT_NONE;
  end

  always_comb begin
    imm32_p0 = '0;
    case (fmt_p0)
      FMT_I: imm32_p0 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: imm32_p0 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: imm32_p0 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: imm32_p0 = {in_instr[31:12], 12'b0};
      FMT_J: imm32_p0 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
      default: imm32_p0 = '0;
    endcase
  end

  assign is_system_p0 = (in_instr[6:0] == OPC_SYSTEM);
  // SYSTEM reads rs1 only for the register forms of CSR access
  assign sys_rs1_p0   = !in_instr[14] && (in_instr[14:12] != 3'b000);
  assign rd_nz_p0     = (in_instr[11:7] != 5'd0);

  always_comb begin
    dec_p0          = '0;
    dec_p0.pc       = in_pc;
    dec_p0.opcode   = in_instr[6:0];
    dec_p0.rd       = REG_ADDR_WIDTH'(in_instr[11:7]);
    dec_p0.rs1      = REG_ADDR_WIDTH'(in_instr[19:15]);
    dec_p0.rs2      = REG_ADDR_WIDTH'(in_instr[24:20]);
    dec_p0.funct3   = in_instr[14:12];
    dec_p0.funct7   = in_instr[31:25];
    dec_p0.fmt      = fmt_p0;
    dec_p0.imm      = sext_xlen(imm32_p0);
    dec_p0.illegal  = (fmt_p0 == FMT_NONE);
    dec_p0.rs1_used = (fmt_p0 == FMT_R || fmt_p0 == FMT_I || fmt_p0 == FMT_S ||
                       fmt_p0 == FMT_B) && (!is_system_p0 || sys_rs1_p0);
    dec_p0.rs2_used = (fmt_p0 == FMT_R || fmt_p0 == FMT_S || fmt_p0 == FMT_B);
    dec_p0.rd_used  = (fmt_p0 == FMT_R || fmt_p0 == FMT_I || fmt_p0 == FMT_U ||
                       fmt_p0 == FMT_J) && rd_nz_p0 &&
                      (in_instr[6:0] != OPC_MISC_MEM);
  end

  entry_t         mem_p1 [DEPTH];
  entry_t         head_p1;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           enq;
  logic           deq;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready && !flush;

  // Stage p1: FIFO storage; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_p1[wr_ptr] <= dec_p0;
  end

  // Storage is not reset, so an empty queue presents an all-zero record
  assign head_p1 = out_valid ? mem_p1[rd_ptr] : '0;

  assign out_pc       = head_p1.pc;
  assign out_opcode   = head_p1.opcode;
  assign out_rd       = head_p1.rd;
  assign out_rs1      = head_p1.rs1;
  assign out_rs2      = head_p1.rs2;
  assign out_funct3   = head_p1.funct3;
  assign out_funct7   = head_p1.funct7;
  assign out_fmt      = head_p1.fmt;
  assign out_imm      = head_p1.imm;
  assign out_rd_used  = head_p1.rd_used;
  assign out_rs1_used = head_p1.rs1_used;
  assign out_rs2_used = head_p1.rs2_used;
  assign out_illegal  = head_p1.illegal;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: an XLEN=32 and an XLEN=64 instance share stimulus.
module tb_instr_decode_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [63:0] in_pc64;
  assign in_pc64 = {32'b0, in_pc};

  logic        in_ready, out_valid, out_rd_used, out_rs1_used, out_rs2_used, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_fmt, count;

  logic        w_in_ready, w_out_valid, w_rd_used, w_rs1_used, w_rs2_used, w_illegal;
  logic [63:0] w_pc, w_imm;
  logic [6:0]  w_opcode, w_funct7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_funct3, w_fmt, w_count;

  instr_decode_queue #(.XLEN(32), .DEPTH(4), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7), .out_fmt(out_fmt),
    .out_imm(out_imm), .out_rd_used(out_rd_used), .out_rs1_used(out_rs1_used),
    .out_rs2_used(out_rs2_used), .out_illegal(out_illegal), .count(count)
  );

  instr_decode_queue #(.XLEN(64), .DEPTH(4), .REG_ADDR_WIDTH(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_pc(w_pc), .out_opcode(w_opcode), .out_rd(w_rd), .out_rs1(w_rs1),
    .out_rs2(w_rs2), .out_funct3(w_funct3), .out_funct7(w_funct7), .out_fmt(w_fmt),
    .out_imm(w_imm), .out_rd_used(w_rd_used), .out_rs1_used(w_rs1_used),
    .out_rs2_used(w_rs2_used), .out_illegal(w_illegal), .count(w_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_empty", {63'b0, out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    tick(); tick();
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'b0, in_ready},  64'd1);
    check("rst_count",     {61'b0, count},     64'd0);
    check("rst_out_pc",    {32'b0, out_pc},    64'd0);
    check("rst_out_imm",   {32'b0, out_imm},   64'd0);
    check("rst_out_fmt",   {61'b0, out_fmt},   64'd0);
    rst_n = 1'b1;
    tick();

    // addi x1,x2,-1
    push(32'hFFF10093, 32'h100);
    check("addi_valid",  {63'b0, out_valid},    64'd1);
    check("addi_count",  {61'b0, count},        64'd1);
    check("addi_pc",     {32'b0, out_pc},       64'h100);
    check("addi_fmt",    {61'b0, out_fmt},      64'd1);
    check("addi_rd",     {59'b0, out_rd},       64'd1);
    check("addi_rs1",    {59'b0, out_rs1},      64'd2);
    check("addi_imm",    {32'b0, out_imm},      64'hFFFFFFFF);
    check("addi_rdu",    {63'b0, out_rd_used},  64'd1);
    check("addi_rs1u",   {63'b0, out_rs1_used}, 64'd1);
    check("addi_rs2u",   {63'b0, out_rs2_used}, 64'd0);
    check("addi_ill",    {63'b0, out_illegal},  64'd0);
    check("addi_imm64",  w_imm,                 64'hFFFF_FFFF_FFFF_FFFF);
    pop();
    check("pop_count", {61'b0, count}, 64'd0);
    check("pop_imm0",  {32'b0, out_imm}, 64'd0);

    // beq x1,x2,-4
    push(32'hFE208EE3, 32'h104);
    check("beq_fmt",  {61'b0, out_fmt},      64'd3);
    check("beq_rs1",  {59'b0, out_rs1},      64'd1);
    check("beq_rs2",  {59'b0, out_rs2},      64'd2);
    check("beq_imm",  {32'b0, out_imm},      64'hFFFFFFFC);
    check("beq_rdu",  {63'b0, out_rd_used},  64'd0);
    check("beq_rs2u", {63'b0, out_rs2_used}, 64'd1);
    pop();

    // lui x5,0x12345
    push(32'h123452B7, 32'h108);
    check("lui_fmt",  {61'b0, out_fmt},      64'd4);
    check("lui_rd",   {59'b0, out_rd},       64'd5);
    check("lui_imm",  {32'b0, out_imm},      64'h12345000);
    check("lui_rdu",  {63'b0, out_rd_used},  64'd1);
    check("lui_rs1u", {63'b0, out_rs1_used}, 64'd0);
    pop();

    // jal x0,8
    push(32'h0080006F, 32'h10C);
    check("jal_fmt", {61'b0, out_fmt},     64'd5);
    check("jal_imm", {32'b0, out_imm},     64'd8);
    check("jal_rdu", {63'b0, out_rd_used}, 64'd0);
    pop();

    // ecall: no register reads
    push(32'h00000073, 32'h110);
    check("ecall_fmt",  {61'b0, out_fmt},      64'd1);
    check("ecall_rs1u", {63'b0, out_rs1_used}, 64'd0);
    check("ecall_ill",  {63'b0, out_illegal},  64'd0);
    pop();

    // csrrs x1,mstatus,x2
    push(32'h300120F3, 32'h114);
    check("csrrs_rs1u", {63'b0, out_rs1_used}, 64'd1);
    check("csrrs_rdu",  {63'b0, out_rd_used},  64'd1);
    check("csrrs_imm",  {32'b0, out_imm},      64'h300);
    pop();

    // all-zero word
    push(32'h00000000, 32'h118);
    check("zero_valid", {63'b0, out_valid},    64'd1);
    check("zero_ill",   {63'b0, out_illegal},  64'd1);
    check("zero_fmt",   {61'b0, out_fmt},      64'd7);
    check("zero_imm",   {32'b0, out_imm},      64'd0);
    check("zero_rs1u",  {63'b0, out_rs1_used}, 64'd0);
    pop();

    // addw x3,x1,x2: illegal at XLEN=32, R-format at XLEN=64
    push(32'h002081BB, 32'h11C);
    check("addw32_ill", {63'b0, out_illegal},  64'd1);
    check("addw32_fmt", {61'b0, out_fmt},      64'd7);
    check("addw32_rdu", {63'b0, out_rd_used},  64'd0);
    check("addw64_ill", {63'b0, w_illegal},    64'd0);
    check("addw64_fmt", {61'b0, w_fmt},        64'd0);
    check("addw64_rs2u",{63'b0, w_rs2_used},   64'd1);
    check("addw64_rdu", {63'b0, w_rd_used},    64'd1);
    check("addw64_pc",  w_pc,                  64'h11C);
    pop();

    // low bits not 11
    push(32'hFFF10090, 32'h120);
    check("lowbits_ill", {63'b0, out_illegal}, 64'd1);
    check("lowbits_imm", {32'b0, out_imm},     64'd0);
    pop();

    // Backpressure: fill to DEPTH, hold a fifth
    in_valid = 1'b1;
    in_instr = 32'h00000013;
    for (int i = 0; i < 4; i++) begin
      in_pc = 32'(4 * i);
      tick();
    end
    check("bp_count_full", {61'b0, count},    64'd4);
    check("bp_not_ready",  {63'b0, in_ready}, 64'd0);
    in_pc = 32'h10;
    tick();
    check("bp_held_count", {61'b0, count},    64'd4);
    check("bp_head_stable",{32'b0, out_pc},   64'h0);
    out_ready = 1'b1;
    tick();
    check("bp_deq1_count", {61'b0, count},    64'd3);
    check("bp_deq1_pc",    {32'b0, out_pc},   64'h4);
    check("bp_deq1_ready", {63'b0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_both_count", {61'b0, count},    64'd3);
    check("bp_both_pc",    {32'b0, out_pc},   64'h8);
    tick();
    check("bp_pc_c",       {32'b0, out_pc},   64'hC);
    tick();
    check("bp_pc_fifth",   {32'b0, out_pc},   64'h10);
    check("bp_cnt_last",   {61'b0, count},    64'd1);
    tick();
    check("bp_drained",    {63'b0, out_valid},64'd0);
    out_ready = 1'b0;

    // Streaming across pointer wrap
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_pc = 32'h200 + 32'(4 * i);
      tick();
      check("wrap_count", {61'b0, count},  64'd1);
      check("wrap_pc",    {32'b0, out_pc}, 64'h200 + 64'(4 * i));
    end
    in_valid = 1'b0;
    tick();
    check("wrap_drain", {61'b0, count}, 64'd0);
    out_ready = 1'b0;

    // Flush with three queued and a same-cycle push and pop
    push(32'h00000013, 32'h300);
    push(32'h00000013, 32'h304);
    push(32'h00000013, 32'h308);
    check("fl_pre_count", {61'b0, count}, 64'd3);
    in_valid = 1'b1; in_pc = 32'h30C; flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("fl_count",  {61'b0, count},     64'd0);
    check("fl_valid",  {63'b0, out_valid}, 64'd0);
    check("fl_ready",  {63'b0, in_ready},  64'd1);
    tick();
    check("fl_dropped",{61'b0, count},     64'd0);
    push(32'h00000013, 32'h400);
    check("fl_after_pc",    {32'b0, out_pc}, 64'h400);
    check("fl_after_count", {61'b0, count},  64'd1);

    // Asynchronous reset mid-stream
    in_valid = 1'b1; in_pc = 32'h404;
    tick();
    check("ar_pre_count", {61'b0, count}, 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {63'b0, out_valid}, 64'd0);
    check("ar_ready", {63'b0, in_ready},  64'd1);
    check("ar_count", {61'b0, count},     64'd0);
    check("ar_pc",    {32'b0, out_pc},    64'd0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_post_valid", {63'b0, out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
